// File: rtl/rv_writeback_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rv_writeback_pkg
// Purpose  : Shared definitions for the uRV writeback stage: load/store
//            funct3 encodings and writeback state encodings.
// Revision : 1.0 - initial release
// ============================================================================
package rv_writeback_pkg;

  // Load size/sign encodings as carried in funct3
  localparam logic [2:0] LDST_B  = 3'b000;
  localparam logic [2:0] LDST_H  = 3'b001;
  localparam logic [2:0] LDST_L  = 3'b010;
  localparam logic [2:0] LDST_BU = 3'b100;
  localparam logic [2:0] LDST_HU = 3'b101;

  // Writeback stage states
  typedef enum logic [0:0] {
    WB_IDLE = 1'b0,
    WB_WAIT = 1'b1
  } wb_state_e;

endpackage
`default_nettype wire

// File: rtl/rv_writeback_load_align.sv
`default_nettype none
// ============================================================================
// Module   : rv_load_align
// Purpose  : Combinational load data alignment. Selects the addressed
//            byte/half/word from a memory data word and sign- or
//            zero-extends it according to funct3.
// Ports    : fun_i     - funct3 of the load
//            addr_i    - low two bits of the load address
//            data_i    - 32-bit word returned by data memory
//            result_o  - extended 32-bit value for the register file
// Revision : 1.0 - initial release
// ============================================================================
module rv_load_align
  import rv_writeback_pkg::*;
(
  input  logic [2:0]  fun_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] result_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'h00;
    case (addr_i)
      2'd0:    byte_sel = data_i[7:0];
      2'd1:    byte_sel = data_i[15:8];
      2'd2:    byte_sel = data_i[23:16];
      default: byte_sel = data_i[31:24];
    endcase
  end

  // Half selection only looks at addr[1]; addr[0] is ignored for halves
  assign half_sel = addr_i[1] ? data_i[31:16] : data_i[15:0];

  always_comb begin
    result_o = 32'h0000_0000;
    case (fun_i)
      LDST_B:  result_o = {{24{byte_sel[7]}}, byte_sel};
      LDST_BU: result_o = {24'h00_0000, byte_sel};
      LDST_H:  result_o = {{16{half_sel[15]}}, half_sel};
      LDST_HU: result_o = {16'h0000, half_sel};
      LDST_L:  result_o = data_i;
      default: result_o = 32'h0000_0000;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/rv_writeback.sv
`default_nettype none
// ============================================================================
// Module   : rv_writeback
// Purpose  : Writeback stage of the uRV pipeline. Forwards ALU results to
//            the register file, collects variable-latency load data,
//            aligns/extends it, requests a stall while a load is pending and
//            aborts loads that exceed LOAD_TIMEOUT cycles in WAIT.
// Ports    : clk_i, rst_i          - clock, synchronous active-high reset
//            x_*                   - registered execute-stage results
//            dm_data_l_i           - load data word from data memory
//            dm_load_done_i        - load data valid this cycle
//            w_stall_req_o         - combinational stall request upstream
//            rf_rd_o/_value_o/_write_o - registered register-file write port
//            w_load_error_o        - one-cycle pulse on load timeout
// Revision : 1.0 - initial release
// ============================================================================
module rv_writeback
  import rv_writeback_pkg::*;
#(
  parameter int LOAD_TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [2:0]  x_fun_i,
  input  logic        x_load_i,
  input  logic [4:0]  x_rd_i,
  input  logic [31:0] x_rd_value_i,
  input  logic        x_rd_write_i,
  input  logic [31:0] x_dm_addr_i,
  input  logic [31:0] dm_data_l_i,
  input  logic        dm_load_done_i,
  output logic        w_stall_req_o,
  output logic [4:0]  rf_rd_o,
  output logic [31:0] rf_rd_value_o,
  output logic        rf_rd_write_o,
  output logic        w_load_error_o
);

  // Counter value seen on the last permitted WAIT cycle
  localparam logic [7:0] TIMEOUT_LAST = 8'(LOAD_TIMEOUT - 1);

  wb_state_e   state_q, state_d;
  logic [7:0]  count_q, count_d;
  logic [4:0]  lat_rd_q, lat_rd_d;
  logic [2:0]  lat_fun_q, lat_fun_d;
  logic [1:0]  lat_addr_q, lat_addr_d;
  logic [4:0]  rf_rd_q, rf_rd_d;
  logic [31:0] rf_rd_value_q, rf_rd_value_d;
  logic        rf_rd_write_q, rf_rd_write_d;
  logic        load_error_q, load_error_d;
  logic        stall;

  logic [2:0]  align_fun;
  logic [1:0]  align_addr;
  logic [31:0] align_result;

  // Only the byte offset of the load address matters here
  logic unused_addr_bits;
  assign unused_addr_bits = ^x_dm_addr_i[31:2];

  // A zero-latency load completes in IDLE and must use the live execute
  // fields; in WAIT the fields latched at accept time are used instead.
  assign align_fun  = (state_q == WB_IDLE) ? x_fun_i          : lat_fun_q;
  assign align_addr = (state_q == WB_IDLE) ? x_dm_addr_i[1:0] : lat_addr_q;

  rv_load_align u_load_align (
    .fun_i    (align_fun),
    .addr_i   (align_addr),
    .data_i   (dm_data_l_i),
    .result_o (align_result)
  );

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    lat_rd_d      = lat_rd_q;
    lat_fun_d     = lat_fun_q;
    lat_addr_d    = lat_addr_q;
    rf_rd_d       = rf_rd_q;
    rf_rd_value_d = rf_rd_value_q;
    rf_rd_write_d = 1'b0;
    load_error_d  = 1'b0;
    stall         = 1'b0;

    case (state_q)
      WB_IDLE: begin
        if (x_load_i) begin
          lat_rd_d   = x_rd_i;
          lat_fun_d  = x_fun_i;
          lat_addr_d = x_dm_addr_i[1:0];
          if (dm_load_done_i) begin
            rf_rd_d       = x_rd_i;
            rf_rd_value_d = align_result;
            rf_rd_write_d = (x_rd_i != 5'd0);
          end else begin
            state_d = WB_WAIT;
            count_d = 8'd0;
            stall   = 1'b1;
          end
        end else if (x_rd_write_i) begin
          rf_rd_d       = x_rd_i;
          rf_rd_value_d = x_rd_value_i;
          rf_rd_write_d = (x_rd_i != 5'd0);
        end
      end

      WB_WAIT: begin
        // Done takes precedence over a timeout in the same cycle
        if (dm_load_done_i) begin
          rf_rd_d       = lat_rd_q;
          rf_rd_value_d = align_result;
          rf_rd_write_d = (lat_rd_q != 5'd0);
          state_d       = WB_IDLE;
        end else begin
          stall = 1'b1;
          if (count_q == TIMEOUT_LAST) begin
            state_d      = WB_IDLE;
            count_d      = 8'd0;
            load_error_d = 1'b1;
          end else begin
            count_d = count_q + 8'd1;
          end
        end
      end

      default: begin
        state_d = WB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= WB_IDLE;
      count_q       <= 8'd0;
      lat_rd_q      <= 5'd0;
      lat_fun_q     <= 3'd0;
      lat_addr_q    <= 2'd0;
      rf_rd_q       <= 5'd0;
      rf_rd_value_q <= 32'h0000_0000;
      rf_rd_write_q <= 1'b0;
      load_error_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      lat_rd_q      <= lat_rd_d;
      lat_fun_q     <= lat_fun_d;
      lat_addr_q    <= lat_addr_d;
      rf_rd_q       <= rf_rd_d;
      rf_rd_value_q <= rf_rd_value_d;
      rf_rd_write_q <= rf_rd_write_d;
      load_error_q  <= load_error_d;
    end
  end

  assign w_stall_req_o  = stall;
  assign rf_rd_o        = rf_rd_q;
  assign rf_rd_value_o  = rf_rd_value_q;
  assign rf_rd_write_o  = rf_rd_write_q;
  assign w_load_error_o = load_error_q;

endmodule
`default_nettype wire

// File: doc/rv_writeback.md
Name: rv_writeback

Overview:
- Writeback stage of the uRV pipeline, directly downstream of the execute stage.
- Consumes the registered execute results: rd index/value/write, load flag, funct3, data-memory address.
- Collects load data from data memory with variable latency, extracts and extends the addressed byte/half/word, and drives the register-file write port.
- Raises a stall request while a load is outstanding and aborts a load that exceeds a timeout.

Parameters:
- LOAD_TIMEOUT, 16, max cycles spent in WAIT before the load is aborted (range 2..255).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- x_fun_i  in  3  funct3 of the instruction leaving execute (load size/sign)
- x_load_i  in  1  instruction is a valid, non-killed load
- x_rd_i  in  5  destination register index
- x_rd_value_i  in  32  ALU result for non-load writes
- x_rd_write_i  in  1  valid, non-killed non-load register write
- x_dm_addr_i  in  32  load address; only [1:0] used
- dm_data_l_i  in  32  load data word from data memory
- dm_load_done_i  in  1  load data valid this cycle
- w_stall_req_o  out  1  stall request to the upstream pipeline
- rf_rd_o  out  5  register-file write index
- rf_rd_value_o  out  32  register-file write data
- rf_rd_write_o  out  1  register-file write enable
- w_load_error_o  out  1  one-cycle pulse on load timeout

Behaviour:
- Reset (synchronous, active-high): state=IDLE, counter=0, rf_rd_o=0, rf_rd_value_o=0, rf_rd_write_o=0, w_load_error_o=0.
  - w_stall_req_o is combinational and is 0 while in IDLE with x_load_i=0.
- rf_* and w_load_error_o are registered: one cycle after accept/completion.
- Non-load write, IDLE with x_rd_write_i=1: next cycle rf_rd_o=x_rd_i, rf_rd_value_o=x_rd_value_i, rf_rd_write_o=(x_rd_i!=0).
  - x_rd_write_i and x_load_i both high: x_load_i takes priority.
  - x_rd_write_i in WAIT is ignored; the bench flags it as an assertion error.
- Load in IDLE, x_load_i=1:
  - Latch rd, fun and addr[1:0].
  - If dm_load_done_i is high the same cycle, complete immediately; state stays IDLE and there is no stall.
  - Otherwise go to WAIT and clear the counter.
- WAIT:
  - Counter increments each cycle.
  - On dm_load_done_i: complete and go to IDLE.
  - If the counter reaches LOAD_TIMEOUT without done: go to IDLE, no rf write, w_load_error_o=1 for one cycle.
  - done and timeout in the same cycle: done wins.
- w_stall_req_o = (IDLE & x_load_i & !dm_load_done_i) | (WAIT & !dm_load_done_i).
  - Drops combinationally in the cycle done arrives, so upstream advances in the same cycle the write is registered.
- Load completion writes rf_rd_o=latched rd and rf_rd_write_o=(rd!=0). rf_rd_value_o by latched fun:
  - LB 000: sign-extend byte addr[1:0] (0 = bits 7:0 … 3 = bits 31:24).
  - LBU 100: zero-extend the same byte.
  - LH 001: sign-extend half selected by addr[1] (0 = bits 15:0, 1 = bits 31:16); addr[0] ignored.
  - LHU 101: zero-extend the same half.
  - LW 010: full word; addr[1:0] ignored.
  - Other fun: write 0.
- rf_rd_write_o is deasserted on every cycle with no completion; it is a single-cycle pulse per write.
- rd=0: value is still driven, write enable is 0.
- Reset while in WAIT: immediate IDLE, stall drops the next cycle, no write, no error pulse.

Decomposition:
- Shared package/defines (rv_defs): add LDST_BU=3'b100 and LDST_HU=3'b101 next to the existing LDST_B/H/L; add WB_IDLE/WB_WAIT state encodings.
- One natural sub-module: rv_load_align.
  - Purely combinational: fun and addr[1:0] plus the data word in, 32-bit extended result out.
  - Reusable by a later forwarding path.

Test Plan:
- ALU write: x_rd_write_i=1, x_rd_i=5, x_rd_value_i=32'h1234_5678 → next cycle rf_rd_write_o=1, rf_rd_o=5, rf_rd_value_o=32'h1234_5678; the following cycle rf_rd_write_o=0.
- Zero-latency LB: x_load_i=1, fun=000, addr=…3, dm_load_done_i=1, data=32'h80AA_BBCC, rd=7 → no stall; next cycle rf_rd_value_o=32'hFFFF_FF80 on x7.
  - Repeat with LBU: 32'h0000_0080.
- Delayed LH: fun=001, addr[1]=1, done after 3 cycles, data=32'h9ABC_0000 →
  - w_stall_req_o=1 for 3 cycles, 0 in the done cycle;
  - next cycle rf_rd_value_o=32'hFFFF_9ABC. Repeat with LHU: 32'h0000_9ABC.
- Timeout: LOAD_TIMEOUT=4, load with done never asserted → stall held through the WAIT cycles, then IDLE; w_load_error_o one-cycle pulse; rf_rd_write_o stays 0.
- rd=0: LW into x0 with data 32'hDEAD_BEEF → rf_rd_write_o=0 throughout.
- Reset mid-WAIT: rst_i=1 on the 2nd WAIT cycle → next cycle stall=0, outputs at reset values. A later done pulse with x_load_i=0 causes no write.
